// File: rtl/top_ejecucion_md_pkg.sv
// rtl/top_ejecucion_md_pkg.sv - shared codes and helpers for the MIPS execute stage
package top_ejecucion_md_pkg;

    localparam logic [3:0] ALU_SLL  = 4'b0000;
    localparam logic [3:0] ALU_SRL  = 4'b0001;
    localparam logic [3:0] ALU_ADDU = 4'b0010;
    localparam logic [3:0] ALU_SRA  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1001;
    localparam logic [3:0] ALU_SUBU = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_LINK = 4'b1110;

    localparam logic [2:0] MD_NONE  = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_MULTU = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_DIVU  = 3'b100;
    localparam logic [2:0] MD_MFHI  = 3'b101;
    localparam logic [2:0] MD_MFLO  = 3'b110;

    localparam logic [1:0] FWD_ID_EX  = 2'b00;
    localparam logic [1:0] FWD_EX_MEM = 2'b01;
    localparam logic [1:0] FWD_MEM_WB = 2'b10;

    localparam int LINK_REG = 31;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (((value - 1) >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic is_md_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_md_hazard(input logic [2:0] op);
        return is_md_arith(op) || (op == MD_MFHI) || (op == MD_MFLO);
    endfunction

endpackage

// File: rtl/top_ejecucion_md_mult_div.sv
// rtl/top_ejecucion_md_mult_div.sv - iterative multiply/divide unit with HI/LO registers
module mult_div_iterativo
    import top_ejecucion_md_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         i_clock,
    input  logic         i_soft_reset,
    input  logic         i_enable,
    input  logic         i_start,
    input  logic [2:0]   i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo,
    output logic         o_busy
);
    localparam int CW = $clog2(W);

    md_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_hi_q, acc_hi_d;
    logic [W-1:0]  acc_lo_q, acc_lo_d;
    logic [W-1:0]  opb_q, opb_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic          is_div_q, is_div_d;
    logic          neg_q, neg_d;
    logic          neg_rem_q, neg_rem_d;
    logic          div0_q, div0_d;
    logic          busy_q, busy_d;

    logic          sgn, a_neg, b_neg;
    logic [W:0]    rem_sh, diff, sum;
    logic [2*W-1:0] prod;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        sgn       = 1'b0;
        a_neg     = 1'b0;
        b_neg     = 1'b0;
        rem_sh    = '0;
        diff      = '0;
        sum       = '0;
        prod      = '0;
        unique case (state_q)
            MD_IDLE: begin
                if (i_start) begin
                    // Iterate on magnitudes; signs are restored in FIX.
                    sgn       = (i_op == MD_MULT) || (i_op == MD_DIV);
                    a_neg     = sgn & i_a[W-1];
                    b_neg     = sgn & i_b[W-1];
                    is_div_d  = (i_op == MD_DIV) || (i_op == MD_DIVU);
                    acc_hi_d  = '0;
                    acc_lo_d  = a_neg ? -i_a : i_a;
                    opb_d     = b_neg ? -i_b : i_b;
                    neg_d     = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    div0_d    = (i_b == '0);
                    cnt_d     = '0;
                    state_d   = MD_RUN;
                end
            end
            MD_RUN: begin
                if (is_div_q) begin
                    rem_sh = {acc_hi_q, acc_lo_q[W-1]};
                    diff   = rem_sh - {1'b0, opb_q};
                    if (rem_sh >= {1'b0, opb_q}) begin
                        acc_hi_d = diff[W-1:0];
                        acc_lo_d = {acc_lo_q[W-2:0], 1'b1};
                    end else begin
                        acc_hi_d = rem_sh[W-1:0];
                        acc_lo_d = {acc_lo_q[W-2:0], 1'b0};
                    end
                end else begin
                    sum      = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
                    acc_hi_d = sum[W:1];
                    acc_lo_d = {sum[0], acc_lo_q[W-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) state_d = MD_FIX;
            end
            MD_FIX: begin
                if (is_div_q) begin
                    lo_d = div0_q ? '1 : (neg_q ? -acc_lo_q : acc_lo_q);
                    hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
                end else begin
                    prod = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
                    hi_d = prod[2*W-1:W];
                    lo_d = prod[W-1:0];
                end
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
        busy_d = (state_d != MD_IDLE);
    end

    always_ff @(posedge i_clock) begin
        if (!i_soft_reset) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else if (i_enable) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            busy_q    <= busy_d;
        end
    end

    assign o_hi   = hi_q;
    assign o_lo   = lo_q;
    assign o_busy = busy_q;

endmodule

// File: rtl/top_ejecucion_md.sv
// rtl/top_ejecucion_md.sv - MIPS execute stage with forwarding, ALU and mult/div unit
module top_ejecucion_md
    import top_ejecucion_md_pkg::*;
#(
    parameter int CANT_BITS_REGISTROS   = 32,
    parameter int CANT_REGISTROS        = 32,
    parameter int CANT_BITS_ADDR        = 11,
    parameter int CANT_BITS_ALU_CONTROL = 4
) (
    input  logic                                  i_clock,
    input  logic                                  i_soft_reset,
    input  logic                                  i_enable_pipeline,
    input  logic [CANT_BITS_ADDR-1:0]             i_adder_pc,
    input  logic [CANT_BITS_REGISTROS-1:0]        i_data_A,
    input  logic [CANT_BITS_REGISTROS-1:0]        i_data_B,
    input  logic [CANT_BITS_REGISTROS-1:0]        i_extension_signo_constante,
    input  logic [clogb2(CANT_REGISTROS)-1:0]     i_reg_rt,
    input  logic [clogb2(CANT_REGISTROS)-1:0]     i_reg_rd,
    input  logic [1:0]                            i_forward_A,
    input  logic [1:0]                            i_forward_B,
    input  logic [CANT_BITS_REGISTROS-1:0]        i_data_ex_mem,
    input  logic [CANT_BITS_REGISTROS-1:0]        i_data_mem_wb,
    input  logic                                  i_RegDst,
    input  logic                                  i_RegWrite,
    input  logic                                  i_ALUSrc,
    input  logic                                  i_MemRead,
    input  logic                                  i_MemWrite,
    input  logic                                  i_MemtoReg,
    input  logic [CANT_BITS_ALU_CONTROL-1:0]      i_ALUCtrl,
    input  logic [2:0]                            i_md_op,
    output logic                                  o_RegWrite,
    output logic                                  o_MemRead,
    output logic                                  o_MemWrite,
    output logic                                  o_MemtoReg,
    output logic [CANT_BITS_REGISTROS-1:0]        o_result,
    output logic [CANT_BITS_REGISTROS-1:0]        o_data_write_to_mem,
    output logic [clogb2(CANT_REGISTROS)-1:0]     o_registro_destino,
    output logic                                  o_stall,
    output logic                                  o_md_busy
);
    localparam int W = CANT_BITS_REGISTROS;
    localparam int R = clogb2(CANT_REGISTROS);
    localparam logic [R-1:0] LINK_IDX = LINK_REG[R-1:0];

    logic [W-1:0] fwd_a, fwd_b, alu_b, alu_res, md_hi, md_lo;
    logic [4:0]   shamt;
    logic [R-1:0] dest;
    logic         md_busy, md_start;

    logic         reg_write_q, reg_write_d;
    logic         mem_read_q, mem_read_d;
    logic         mem_write_q, mem_write_d;
    logic         mem_to_reg_q, mem_to_reg_d;
    logic [W-1:0] result_q, result_d;
    logic [W-1:0] wdata_q, wdata_d;
    logic [R-1:0] dest_q, dest_d;

    assign o_stall  = md_busy & is_md_hazard(i_md_op);
    assign md_start = !md_busy & is_md_arith(i_md_op);

    mult_div_iterativo #(.W(W)) u_mult_div (
        .i_clock      (i_clock),
        .i_soft_reset (i_soft_reset),
        .i_enable     (i_enable_pipeline),
        .i_start      (md_start),
        .i_op         (i_md_op),
        .i_a          (fwd_a),
        .i_b          (fwd_b),
        .o_hi         (md_hi),
        .o_lo         (md_lo),
        .o_busy       (md_busy)
    );

    always_comb begin
        fwd_a = i_data_A;
        fwd_b = i_data_B;
        unique case (i_forward_A)
            FWD_EX_MEM: fwd_a = i_data_ex_mem;
            FWD_MEM_WB: fwd_a = i_data_mem_wb;
            default:    fwd_a = i_data_A;
        endcase
        unique case (i_forward_B)
            FWD_EX_MEM: fwd_b = i_data_ex_mem;
            FWD_MEM_WB: fwd_b = i_data_mem_wb;
            default:    fwd_b = i_data_B;
        endcase
        alu_b = i_ALUSrc ? i_extension_signo_constante : fwd_b;
        shamt = i_extension_signo_constante[10:6];
    end

    always_comb begin
        alu_res = '0;
        case (i_ALUCtrl)
            ALU_SLL:  alu_res = fwd_b << shamt;
            ALU_SRL:  alu_res = fwd_b >> shamt;
            ALU_SRA:  alu_res = $signed(fwd_b) >>> shamt;
            ALU_ADDU: alu_res = fwd_a + alu_b;
            ALU_SUBU: alu_res = fwd_a - alu_b;
            ALU_AND:  alu_res = fwd_a & alu_b;
            ALU_OR:   alu_res = fwd_a | alu_b;
            ALU_XOR:  alu_res = fwd_a ^ alu_b;
            ALU_NOR:  alu_res = ~(fwd_a | alu_b);
            ALU_SLT:  alu_res[0] = $signed(fwd_a) < $signed(alu_b);
            ALU_SLTU: alu_res[0] = fwd_a < alu_b;
            ALU_LUI:  alu_res = {alu_b[W/2-1:0], {(W/2){1'b0}}};
            ALU_LINK: alu_res[CANT_BITS_ADDR-1:0] = i_adder_pc;
            default:  alu_res = '0;
        endcase
        if (i_ALUCtrl == ALU_LINK) dest = LINK_IDX;
        else                       dest = i_RegDst ? i_reg_rd : i_reg_rt;
    end

    always_comb begin
        reg_write_d  = i_RegWrite;
        mem_read_d   = i_MemRead;
        mem_write_d  = i_MemWrite;
        mem_to_reg_d = i_MemtoReg;
        wdata_d      = fwd_b;
        dest_d       = dest;
        result_d     = alu_res;
        if (i_md_op == MD_MFHI)      result_d = md_hi;
        else if (i_md_op == MD_MFLO) result_d = md_lo;
        // A held instruction must not reach EX/MEM twice, so the stage emits a bubble.
        if (o_stall) begin
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            wdata_d      = '0;
            dest_d       = '0;
            result_d     = '0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_soft_reset) begin
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            result_q     <= '0;
            wdata_q      <= '0;
            dest_q       <= '0;
        end else if (i_enable_pipeline) begin
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            result_q     <= result_d;
            wdata_q      <= wdata_d;
            dest_q       <= dest_d;
        end
    end

    assign o_RegWrite          = reg_write_q;
    assign o_MemRead           = mem_read_q;
    assign o_MemWrite          = mem_write_q;
    assign o_MemtoReg          = mem_to_reg_q;
    assign o_result            = result_q;
    assign o_data_write_to_mem = wdata_q;
    assign o_registro_destino  = dest_q;
    assign o_md_busy           = md_busy;

endmodule

// File: tb/tb_top_ejecucion_md.sv
// tb/tb_top_ejecucion_md.sv - self-checking bench for the execute stage
module tb_top_ejecucion_md;
    import top_ejecucion_md_pkg::*;

    localparam int W = 32;

    logic        i_clock = 1'b0;
    logic        i_soft_reset, i_enable_pipeline;
    logic [10:0] i_adder_pc;
    logic [31:0] i_data_A, i_data_B, i_extension_signo_constante;
    logic [4:0]  i_reg_rt, i_reg_rd;
    logic [1:0]  i_forward_A, i_forward_B;
    logic [31:0] i_data_ex_mem, i_data_mem_wb;
    logic        i_RegDst, i_RegWrite, i_ALUSrc, i_MemRead, i_MemWrite, i_MemtoReg;
    logic [3:0]  i_ALUCtrl;
    logic [2:0]  i_md_op;
    logic        o_RegWrite, o_MemRead, o_MemWrite, o_MemtoReg;
    logic [31:0] o_result, o_data_write_to_mem;
    logic [4:0]  o_registro_destino;
    logic        o_stall, o_md_busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a, b, imm, exmem, memwb;
        logic [1:0]  fa, fb;
        logic        alusrc, regdst, memwr;
        logic [4:0]  rt, rd;
        logic [10:0] pc;
        logic [31:0] e_res, e_wdata;
        logic [4:0]  e_dst;
    } alu_vec_t;

    typedef struct {
        logic [31:0] res, wdata;
        logic [4:0]  dst;
        logic        memwr;
    } alu_exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, lo, hi;
    } md_vec_t;

    alu_vec_t    vecs[$];
    alu_exp_t    sb_alu[$];
    logic [31:0] sb_md[$];

    top_ejecucion_md dut (
        .i_clock(i_clock), .i_soft_reset(i_soft_reset), .i_enable_pipeline(i_enable_pipeline),
        .i_adder_pc(i_adder_pc), .i_data_A(i_data_A), .i_data_B(i_data_B),
        .i_extension_signo_constante(i_extension_signo_constante),
        .i_reg_rt(i_reg_rt), .i_reg_rd(i_reg_rd),
        .i_forward_A(i_forward_A), .i_forward_B(i_forward_B),
        .i_data_ex_mem(i_data_ex_mem), .i_data_mem_wb(i_data_mem_wb),
        .i_RegDst(i_RegDst), .i_RegWrite(i_RegWrite), .i_ALUSrc(i_ALUSrc),
        .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite), .i_MemtoReg(i_MemtoReg),
        .i_ALUCtrl(i_ALUCtrl), .i_md_op(i_md_op),
        .o_RegWrite(o_RegWrite), .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite),
        .o_MemtoReg(o_MemtoReg), .o_result(o_result), .o_data_write_to_mem(o_data_write_to_mem),
        .o_registro_destino(o_registro_destino), .o_stall(o_stall), .o_md_busy(o_md_busy)
    );

    always #5 i_clock = ~i_clock;

    task automatic clear_inputs();
        i_enable_pipeline = 1'b1;
        i_adder_pc = '0; i_data_A = '0; i_data_B = '0; i_extension_signo_constante = '0;
        i_reg_rt = '0; i_reg_rd = '0; i_forward_A = 2'b00; i_forward_B = 2'b00;
        i_data_ex_mem = '0; i_data_mem_wb = '0;
        i_RegDst = 0; i_RegWrite = 0; i_ALUSrc = 0; i_MemRead = 0; i_MemWrite = 0; i_MemtoReg = 0;
        i_ALUCtrl = 4'b1111; i_md_op = MD_NONE;
    endtask

    task automatic add_vec(input logic [3:0] ctrl, input logic [31:0] a, b, imm, exmem, memwb,
                           input logic [1:0] fa, fb, input logic alusrc, regdst, memwr,
                           input logic [4:0] rt, rd, input logic [10:0] pc,
                           input logic [31:0] e_res, e_wdata, input logic [4:0] e_dst);
        alu_vec_t v;
        v.ctrl = ctrl; v.a = a; v.b = b; v.imm = imm; v.exmem = exmem; v.memwb = memwb;
        v.fa = fa; v.fb = fb; v.alusrc = alusrc; v.regdst = regdst; v.memwr = memwr;
        v.rt = rt; v.rd = rd; v.pc = pc; v.e_res = e_res; v.e_wdata = e_wdata; v.e_dst = e_dst;
        vecs.push_back(v);
    endtask

    // Issues op, then MFLO (held against the busy unit), then MFHI; returns what EX/MEM showed.
    task automatic md_sequence(input logic [2:0] op, input logic [31:0] a, b,
                               input int freeze_at, input int freeze_len,
                               output int stalls, output int bubble_bad,
                               output logic [31:0] r_lo, output logic [31:0] r_hi);
        clear_inputs();
        i_md_op = op; i_data_A = a; i_data_B = b;
        @(posedge i_clock); #1;
        i_md_op = MD_MFLO; i_RegWrite = 1; i_RegDst = 1; i_reg_rd = 5'd8;
        #1;
        stalls = 0; bubble_bad = 0;
        while (o_stall && stalls < 200) begin
            i_enable_pipeline = !(freeze_len > 0 && stalls >= freeze_at && stalls < freeze_at + freeze_len);
            @(posedge i_clock); #1;
            stalls++;
            if (o_RegWrite !== 1'b0 || o_result !== 32'h0 || o_MemWrite !== 1'b0) bubble_bad++;
        end
        i_enable_pipeline = 1'b1;
        @(posedge i_clock); #1;
        r_lo = o_result;
        i_md_op = MD_MFHI;
        @(posedge i_clock); #1;
        r_hi = o_result;
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        i_soft_reset = 1'b0;
        i_RegWrite = 1; i_MemRead = 1; i_MemWrite = 1; i_MemtoReg = 1;
        i_data_A = 32'h11; i_data_B = 32'h22; i_ALUCtrl = ALU_ADDU; i_md_op = MD_MFHI;
        repeat (2) @(posedge i_clock);
        #1;
        n_checks++;
        if ({o_RegWrite, o_MemRead, o_MemWrite, o_MemtoReg} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl got=%b exp=0000", {o_RegWrite, o_MemRead, o_MemWrite, o_MemtoReg});
        end
        n_checks++;
        if (o_result !== 32'h0 || o_data_write_to_mem !== 32'h0 || o_registro_destino !== 5'd0) begin
            n_fail++; $display("FAIL reset_data got res=%h wd=%h dst=%0d exp 0", o_result, o_data_write_to_mem, o_registro_destino);
        end
        n_checks++;
        if (o_md_busy !== 1'b0 || o_stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got busy=%b stall=%b exp 0", o_md_busy, o_stall);
        end
        i_soft_reset = 1'b1;
        clear_inputs();
        @(posedge i_clock); #1;
    endtask

    task automatic test_alu();
        alu_exp_t e;
        vecs.delete();
        //      ctrl      a             b             imm           exmem  memwb  fa     fb     src rd mw rt  rd  pc   e_res         e_wdata       dst
        add_vec(ALU_ADDU, 32'd1,        32'd2,        32'h0,        32'h0, 32'h0, 2'b00, 2'b00, 0,  1, 0, 0,  3,  0,   32'd3,        32'd2,        3);
        add_vec(ALU_LUI,  32'h0,        32'h0,        32'h1234,     32'h0, 32'h0, 2'b00, 2'b00, 1,  0, 1, 4,  9,  0,   32'h12340000, 32'h0,        4);
        add_vec(ALU_LINK, 32'h0,        32'h0,        32'h0,        32'h0, 32'h0, 2'b00, 2'b00, 0,  1, 0, 1,  2,  5,   32'd5,        32'h0,        31);
        add_vec(ALU_SUBU, 32'd100,      32'd200,      32'h0,        32'd7, 32'd9, 2'b01, 2'b10, 0,  1, 1, 0,  6,  0,   32'hFFFFFFFE, 32'd9,        6);
        add_vec(ALU_SLL,  32'h0,        32'd1,        32'h100,      32'h0, 32'h0, 2'b00, 2'b00, 0,  0, 0, 7,  0,  0,   32'h10,       32'd1,        7);
        add_vec(ALU_SRA,  32'h0,        32'h80000000, 32'h100,      32'h0, 32'h0, 2'b00, 2'b00, 0,  0, 0, 7,  0,  0,   32'hF8000000, 32'h80000000, 7);
        add_vec(ALU_SRL,  32'h0,        32'h80000000, 32'h7C0,      32'h0, 32'h0, 2'b00, 2'b00, 0,  0, 0, 7,  0,  0,   32'd1,        32'h80000000, 7);
        add_vec(ALU_SLT,  32'hFFFFFFFF, 32'd1,        32'h0,        32'h0, 32'h0, 2'b00, 2'b00, 0,  1, 0, 0,  10, 0,   32'd1,        32'd1,        10);
        add_vec(ALU_SLTU, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0, 32'h0, 2'b00, 2'b00, 0,  1, 0, 0,  11, 0,   32'd0,        32'd1,        11);
        add_vec(ALU_NOR,  32'hF0F00000, 32'h0F0F0000, 32'h0,        32'h0, 32'h0, 2'b00, 2'b00, 0,  1, 0, 0,  12, 0,   32'h0000FFFF, 32'h0F0F0000, 12);
        add_vec(ALU_XOR,  32'hFF00FF00, 32'h0FF00FF0, 32'h0,        32'h0, 32'h0, 2'b00, 2'b00, 0,  1, 0, 0,  13, 0,   32'hF0F0F0F0, 32'h0FF00FF0, 13);
        add_vec(4'b1111,  32'd5,        32'd6,        32'h0,        32'h0, 32'h0, 2'b00, 2'b00, 0,  1, 0, 0,  14, 0,   32'd0,        32'd6,        14);
        add_vec(ALU_ADDU, 32'd10,       32'd20,       32'h0,        32'd99,32'd77,2'b11, 2'b11, 0,  1, 0, 0,  15, 0,   32'd30,       32'd20,       15);
        foreach (vecs[i]) begin
            clear_inputs();
            i_ALUCtrl = vecs[i].ctrl; i_data_A = vecs[i].a; i_data_B = vecs[i].b;
            i_extension_signo_constante = vecs[i].imm; i_data_ex_mem = vecs[i].exmem;
            i_data_mem_wb = vecs[i].memwb; i_forward_A = vecs[i].fa; i_forward_B = vecs[i].fb;
            i_ALUSrc = vecs[i].alusrc; i_RegDst = vecs[i].regdst; i_MemWrite = vecs[i].memwr;
            i_reg_rt = vecs[i].rt; i_reg_rd = vecs[i].rd; i_adder_pc = vecs[i].pc; i_RegWrite = 1;
            sb_alu.push_back('{vecs[i].e_res, vecs[i].e_wdata, vecs[i].e_dst, vecs[i].memwr});
            @(posedge i_clock); #1;
            e = sb_alu.pop_front();
            n_checks++;
            if (o_result !== e.res || o_registro_destino !== e.dst || o_data_write_to_mem !== e.wdata
                || o_RegWrite !== 1'b1 || o_MemWrite !== e.memwr) begin
                n_fail++;
                $display("FAIL alu[%0d] got res=%h dst=%0d wd=%h rw=%b mw=%b exp res=%h dst=%0d wd=%h rw=1 mw=%b",
                         i, o_result, o_registro_destino, o_data_write_to_mem, o_RegWrite, o_MemWrite,
                         e.res, e.dst, e.wdata, e.memwr);
            end
        end
        clear_inputs();
    endtask

    task automatic test_mult();
        int st, bb;
        logic [31:0] lo, hi, exp_v;
        sb_md.push_back(32'hFFFFFFF1);
        sb_md.push_back(32'hFFFFFFFF);
        md_sequence(MD_MULT, 32'hFFFFFFFD, 32'd5, 0, 0, st, bb, lo, hi);
        n_checks++;
        if (st !== W + 1) begin n_fail++; $display("FAIL mult_stall_cycles got=%0d exp=%0d", st, W + 1); end
        n_checks++;
        if (bb !== 0) begin n_fail++; $display("FAIL mult_bubbles got=%0d non-bubble cycles exp=0", bb); end
        exp_v = sb_md.pop_front();
        n_checks++;
        if (lo !== exp_v) begin n_fail++; $display("FAIL mult_lo got=%h exp=%h", lo, exp_v); end
        exp_v = sb_md.pop_front();
        n_checks++;
        if (hi !== exp_v) begin n_fail++; $display("FAIL mult_hi got=%h exp=%h", hi, exp_v); end
    endtask

    task automatic test_div();
        md_vec_t mdv[4];
        int st, bb;
        logic [31:0] lo, hi, exp_v;
        mdv[0] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
        mdv[1] = '{MD_DIVU,  32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234};
        mdv[2] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
        mdv[3] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};
        for (int k = 0; k < 4; k++) begin
            sb_md.push_back(mdv[k].lo);
            sb_md.push_back(mdv[k].hi);
            md_sequence(mdv[k].op, mdv[k].a, mdv[k].b, 0, 0, st, bb, lo, hi);
            n_checks++;
            if (st !== W + 1 || bb !== 0) begin
                n_fail++; $display("FAIL md[%0d]_timing got stalls=%0d bad=%0d exp stalls=%0d bad=0", k, st, bb, W + 1);
            end
            exp_v = sb_md.pop_front();
            n_checks++;
            if (lo !== exp_v) begin n_fail++; $display("FAIL md[%0d]_lo got=%h exp=%h", k, lo, exp_v); end
            exp_v = sb_md.pop_front();
            n_checks++;
            if (hi !== exp_v) begin n_fail++; $display("FAIL md[%0d]_hi got=%h exp=%h", k, hi, exp_v); end
        end
    endtask

    task automatic test_enable_freeze();
        int st, bb;
        logic [31:0] lo, hi, exp_v;
        sb_md.push_back(32'h002DC6C0);
        sb_md.push_back(32'h00000000);
        md_sequence(MD_MULTU, 32'd1000, 32'd3000, 10, 5, st, bb, lo, hi);
        n_checks++;
        if (st !== W + 1 + 5) begin n_fail++; $display("FAIL freeze_stall_cycles got=%0d exp=%0d", st, W + 6); end
        exp_v = sb_md.pop_front();
        n_checks++;
        if (lo !== exp_v) begin n_fail++; $display("FAIL freeze_lo got=%h exp=%h", lo, exp_v); end
        exp_v = sb_md.pop_front();
        n_checks++;
        if (hi !== exp_v) begin n_fail++; $display("FAIL freeze_hi got=%h exp=%h", hi, exp_v); end
    endtask

    task automatic test_reset_mid_run();
        clear_inputs();
        i_md_op = MD_MULT; i_data_A = 32'd6; i_data_B = 32'd7;
        @(posedge i_clock); #1;
        i_md_op = MD_NONE;
        repeat (10) @(posedge i_clock);
        #1;
        n_checks++;
        if (o_md_busy !== 1'b1) begin n_fail++; $display("FAIL midrun_busy got=%b exp=1", o_md_busy); end
        i_soft_reset = 1'b0;
        @(posedge i_clock); #1;
        i_soft_reset = 1'b1;
        n_checks++;
        if (o_md_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", o_md_busy); end
        i_md_op = MD_MFHI; i_RegWrite = 1; i_RegDst = 1; i_reg_rd = 5'd9;
        #1;
        n_checks++;
        if (o_stall !== 1'b0) begin n_fail++; $display("FAIL abort_stall got=%b exp=0", o_stall); end
        @(posedge i_clock); #1;
        n_checks++;
        if (o_result !== 32'h0 || o_RegWrite !== 1'b1 || o_registro_destino !== 5'd9) begin
            n_fail++; $display("FAIL abort_mfhi got res=%h rw=%b dst=%0d exp res=0 rw=1 dst=9", o_result, o_RegWrite, o_registro_destino);
        end
        i_md_op = MD_MFLO;
        @(posedge i_clock); #1;
        n_checks++;
        if (o_result !== 32'h0) begin n_fail++; $display("FAIL abort_mflo got=%h exp=0", o_result); end
        n_checks++;
        if (o_md_busy !== 1'b0) begin n_fail++; $display("FAIL abort_restart got busy=%b exp=0", o_md_busy); end
        clear_inputs();
    endtask

    initial begin
        i_soft_reset = 1'b0;
        clear_inputs();
        test_reset();
        test_alu();
        test_mult();
        test_div();
        test_enable_freeze();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/top_ejecucion_md.md
# top_ejecucion_md

Parametrised execute stage for the MIPS pipeline, sitting between the ID/EX and EX/MEM boundaries. It generalises the single-cycle execute stage with three additions:
- operand forwarding muxes;
- a full ALU operation set;
- an iterative multiply/divide unit with HI/LO registers, which raises a stall toward the hazard unit while busy.

It registers all results and pass-through control into the EX/MEM outputs.

## Interface
Parameters:
- CANT_BITS_REGISTROS, 32, datapath width W (even, ≥8)
- CANT_REGISTROS, 32, register file depth; register index width R = clog2(CANT_REGISTROS)
- CANT_BITS_ADDR, 11, PC width (≤ W)
- CANT_BITS_ALU_CONTROL, 4, ALU control width

Ports:
- i_clock  in  1  single clock, rising edge
- i_soft_reset  in  1  synchronous, active-low reset
- i_enable_pipeline  in  1  global advance enable; low freezes every register, including the mult/div unit
- i_adder_pc  in  CANT_BITS_ADDR  PC+1 of the instruction
- i_data_A, i_data_B  in  W  register operands from ID/EX
- i_extension_signo_constante  in  W  sign-extended immediate; bits [10:6] carry shamt
- i_reg_rt, i_reg_rd  in  R  destination candidates
- i_forward_A, i_forward_B  in  2  operand source select: 00 ID/EX, 01 i_data_ex_mem, 10 i_data_mem_wb, 11 treated as 00
- i_data_ex_mem, i_data_mem_wb  in  W  forwarded values
- i_RegDst, i_RegWrite, i_ALUSrc, i_MemRead, i_MemWrite, i_MemtoReg  in  1  control
- i_ALUCtrl  in  CANT_BITS_ALU_CONTROL  ALU operation
- i_md_op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MFHI, 110 MFLO, 111 none
- o_RegWrite, o_MemRead, o_MemWrite, o_MemtoReg  out  1  registered control
- o_result, o_data_write_to_mem  out  W  registered ALU result and store data
- o_registro_destino  out  R  registered destination register
- o_stall  out  1  combinational; high means the upstream must hold ID/EX
- o_md_busy  out  1  registered; the mult/div unit is iterating

## Operation
- Operand A is the forwarded A. Operand B is the immediate when i_ALUSrc=1, otherwise the forwarded B. o_data_write_to_mem always takes the forwarded B.
- ALU codes:
  - 0000 SLL, 0001 SRL, 0011 SRA: shift the forwarded B by imm[10:6].
  - 0010 ADDU, 1010 SUBU: arithmetic modulo 2^W, no overflow trap.
  - 0100 AND, 0101 OR, 0110 XOR, 1001 NOR.
  - 0111 SLT (signed), 1011 SLTU: result is 1 or 0.
  - 1000 LUI: B[W/2-1:0] placed in the upper half, lower half zero.
  - 1110 LINK: zero-extended i_adder_pc.
  - Any other code gives result 0.
- Destination: 31 when LINK; otherwise rd if i_RegDst=1, else rt.
- MFHI/MFLO override the ALU result with HI/LO.
- Mult/div unit:
  - States: IDLE, RUN (W iterations, shift-add or restoring divide on magnitudes), FIX (sign correction, HI/LO write), then back to IDLE.
  - MULT/MULTU produce the 2W-bit product: HI holds the upper half, LO the lower half.
  - DIV/DIVU write LO = quotient and HI = remainder; the remainder takes the dividend's sign.
  - Divisor 0: LO = all ones, HI = dividend.
  - Most-negative / -1: LO = most-negative, HI = 0.
- Hazard rule: o_stall = o_md_busy AND i_md_op in {MULT, MULTU, DIV, DIVU, MFHI, MFLO}. While o_stall is high, EX/MEM loads a bubble (all control 0, result 0) and the held instruction is not consumed.
- An md op arriving while the unit is IDLE is consumed in one cycle; MULT/DIV pass through EX/MEM with their own control as given.

## Timing
- Reset (i_soft_reset=0 at an edge):
  - all outputs 0 and the unit in IDLE;
  - HI and LO set to 0;
  - an in-flight operation is aborted.
- ALU path latency: 1 cycle, from the input edge to the EX/MEM outputs.
- MULT/DIV accepted at edge t:
  - o_md_busy is high from t+1 through t+W+1;
  - HI and LO are valid after edge t+W+1, so MFHI/MFLO can complete at t+W+2 at the earliest;
  - an MFHI held against the busy unit is consumed on the first edge where o_md_busy=0.
- i_enable_pipeline=0: no register changes, no iteration progress, o_stall still evaluated combinationally.
- Reset and enable are evaluated together: reset wins.

## Structure
- Shared package holds the ALU codes, the i_md_op encodings, the forward-select codes, the LINK register index (31) and a clogb2 function.
- One sub-module, mult_div_iterativo, contains the FSM, counter, HI/LO registers and busy flag. The ALU and the muxes stay in the top level.

## Test plan
- A=1, B=2, ALUCtrl=0010, RegDst=1, rd=3 -> one cycle later o_result=3, o_registro_destino=3.
- ALUCtrl=1000, ALUSrc=1, imm=0x0000_1234 -> o_result=0x1234_0000. ALUCtrl=1110, adder_pc=5 -> o_result=5, o_registro_destino=31.
- forward_A=01 with i_data_ex_mem=7, forward_B=10 with i_data_mem_wb=9, SUBU -> o_result=0xFFFF_FFFE.
- MULT with A=-3, B=5, followed by MFLO then MFHI -> o_stall high for W+1 cycles with bubbles in EX/MEM; afterwards o_result=0xFFFF_FFF1, then 0xFFFF_FFFF.
- DIV with A=-7, B=2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU with B=0 -> LO=0xFFFF_FFFF, HI=A.
- Reset asserted mid-RUN -> o_md_busy=0 next cycle and MFHI returns 0. Enable held low for 5 cycles mid-RUN -> completion is delayed by exactly 5 cycles.
